// File: rtl/change_payout_if.sv
// Request/ejector/status bundle between the vending FSM side and the change payout block.
interface change_payout_if;
  localparam int unsigned AMT_W = 6;
  localparam int unsigned CNT_W = 8;

  logic             charge_ind;
  logic [AMT_W-1:0] coin_sum;
  logic             refill;
  logic             eject;
  logic [1:0]       eject_val;
  logic             busy;
  logic             done;
  logic [AMT_W-1:0] short_amt;
  logic [CNT_W-1:0] n5;
  logic [CNT_W-1:0] n1;
  logic [CNT_W-1:0] n05;

  modport master (
    output charge_ind, coin_sum, refill,
    input  eject, eject_val, busy, done, short_amt, n5, n1, n05
  );

  modport slave (
    input  charge_ind, coin_sum, refill,
    output eject, eject_val, busy, done, short_amt, n5, n1, n05
  );
endinterface

// File: rtl/change_payout.sv
// Coin-return dispenser: greedy 5/1/0.5-yuan decomposition of a Q1 amount,
// one coin per eject pulse, with per-denomination inventory and shortfall report.
module change_payout #(
  parameter int unsigned INIT_N5   = 8,
  parameter int unsigned INIT_N1   = 20,
  parameter int unsigned INIT_N05  = 20,
  parameter int unsigned EJECT_GAP = 2
) (
  input logic            clk,
  input logic            rst_n,
  change_payout_if.slave bus
);

  localparam int unsigned AMT_W = 6;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = (EJECT_GAP < 2) ? 1 : $clog2(EJECT_GAP + 1);

  localparam logic [1:0] COIN_05 = 2'b00;
  localparam logic [1:0] COIN_1  = 2'b01;
  localparam logic [1:0] COIN_5  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             charge_q;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [1:0]       sel_q, sel_d;
  logic             eject_q, eject_d;
  logic [1:0]       eject_val_q, eject_val_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] short_q, short_d;
  logic [CNT_W-1:0] n5_q, n5_d;
  logic [CNT_W-1:0] n1_q, n1_d;
  logic [CNT_W-1:0] n05_q, n05_d;
  logic             start;

  function automatic logic [AMT_W-1:0] coin_q1(input logic [1:0] code);
    case (code)
      COIN_5:  coin_q1 = AMT_W'(10);
      COIN_1:  coin_q1 = AMT_W'(2);
      default: coin_q1 = AMT_W'(1);
    endcase
  endfunction

  assign start = bus.charge_ind & ~charge_q;

  // Next-state, datapath updates and registered-output precompute
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    sel_d       = sel_q;
    short_d     = short_q;
    n5_d        = n5_q;
    n1_d        = n1_q;
    n05_d       = n05_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_SELECT;
          remaining_d = bus.coin_sum;
          short_d     = '0;
        end else if (bus.refill) begin
          n5_d  = CNT_W'(INIT_N5);
          n1_d  = CNT_W'(INIT_N1);
          n05_d = CNT_W'(INIT_N05);
        end
      end
      S_SELECT: begin
        if (remaining_q == '0) begin
          state_d = S_DONE;
        end else if ((remaining_q >= AMT_W'(10)) && (n5_q != '0)) begin
          sel_d   = COIN_5;
          state_d = S_EJECT;
        end else if ((remaining_q >= AMT_W'(2)) && (n1_q != '0)) begin
          sel_d   = COIN_1;
          state_d = S_EJECT;
        end else if (n05_q != '0) begin
          sel_d   = COIN_05;
          state_d = S_EJECT;
        end else begin
          short_d     = remaining_q;
          remaining_d = '0;
          state_d     = S_DONE;
        end
      end
      S_EJECT: begin
        case (sel_q)
          COIN_5:  if (n5_q  != '0) n5_d  = n5_q  - CNT_W'(1);
          COIN_1:  if (n1_q  != '0) n1_d  = n1_q  - CNT_W'(1);
          default: if (n05_q != '0) n05_d = n05_q - CNT_W'(1);
        endcase
        remaining_d = remaining_q - coin_q1(sel_q);
        gap_d       = GAP_W'(EJECT_GAP);
        state_d     = S_GAP;
      end
      S_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          state_d = S_SELECT;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered so they line up with the state being entered
    eject_d     = (state_d == S_EJECT);
    eject_val_d = eject_d ? sel_d : eject_val_q;
    busy_d      = (state_d == S_SELECT) || (state_d == S_EJECT) || (state_d == S_GAP);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      charge_q    <= 1'b0;
      remaining_q <= '0;
      gap_q       <= '0;
      sel_q       <= COIN_05;
      eject_q     <= 1'b0;
      eject_val_q <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      short_q     <= '0;
      n5_q        <= CNT_W'(INIT_N5);
      n1_q        <= CNT_W'(INIT_N1);
      n05_q       <= CNT_W'(INIT_N05);
    end else begin
      state_q     <= state_d;
      charge_q    <= bus.charge_ind;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      sel_q       <= sel_d;
      eject_q     <= eject_d;
      eject_val_q <= eject_val_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      short_q     <= short_d;
      n5_q        <= n5_d;
      n1_q        <= n1_d;
      n05_q       <= n05_d;
    end
  end

  assign bus.eject     = eject_q;
  assign bus.eject_val = eject_val_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.short_amt = short_q;
  assign bus.n5        = n5_q;
  assign bus.n1        = n1_q;
  assign bus.n05       = n05_q;

endmodule

// File: tb/tb_change_payout.sv
// Bench for change_payout: three inventory configurations driven in parallel,
// checked against a greedy arithmetic model of coins, timing, shortfall and counts.
module tb_change_payout;
  localparam int G  = 2;
  localparam int ND = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       charge_ind = 1'b0;
  logic       refill = 1'b0;
  logic [5:0] coin_sum = 6'd0;

  change_payout_if ifa ();
  change_payout_if ifb ();
  change_payout_if ifc ();

  assign ifa.charge_ind = charge_ind;
  assign ifa.coin_sum   = coin_sum;
  assign ifa.refill     = refill;
  assign ifb.charge_ind = charge_ind;
  assign ifb.coin_sum   = coin_sum;
  assign ifb.refill     = refill;
  assign ifc.charge_ind = charge_ind;
  assign ifc.coin_sum   = coin_sum;
  assign ifc.refill     = refill;

  change_payout #(.INIT_N5(8), .INIT_N1(20), .INIT_N05(20), .EJECT_GAP(G)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  change_payout #(.INIT_N5(0), .INIT_N1(20), .INIT_N05(20), .EJECT_GAP(G)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));
  change_payout #(.INIT_N5(0), .INIT_N1(1), .INIT_N05(1), .EJECT_GAP(G)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc));

  always #5 clk = ~clk;

  logic       ej [ND];
  logic [1:0] ejv[ND];
  logic       bsy[ND];
  logic       dn [ND];
  logic [5:0] sht[ND];
  logic [7:0] c5 [ND];
  logic [7:0] c1 [ND];
  logic [7:0] c05[ND];

  always_comb begin
    ej[0] = ifa.eject; ejv[0] = ifa.eject_val; bsy[0] = ifa.busy; dn[0] = ifa.done;
    sht[0] = ifa.short_amt; c5[0] = ifa.n5; c1[0] = ifa.n1; c05[0] = ifa.n05;
    ej[1] = ifb.eject; ejv[1] = ifb.eject_val; bsy[1] = ifb.busy; dn[1] = ifb.done;
    sht[1] = ifb.short_amt; c5[1] = ifb.n5; c1[1] = ifb.n1; c05[1] = ifb.n05;
    ej[2] = ifc.eject; ejv[2] = ifc.eject_val; bsy[2] = ifc.busy; dn[2] = ifc.done;
    sht[2] = ifc.short_amt; c5[2] = ifc.n5; c1[2] = ifc.n1; c05[2] = ifc.n05;
  end

  int init5 [ND] = '{8, 0, 0};
  int init1 [ND] = '{20, 20, 1};
  int init05[ND] = '{20, 20, 1};

  int m5[ND], m1[ND], m05[ND];
  int exp_k[ND], exp_short[ND];
  int exp_code[ND][64];
  int got_k[ND], done_cyc[ND], done_cnt[ND], busy_cnt[ND];
  int got_cyc[ND][64];
  int got_val[ND][64];

  int total = 0;
  int bad = 0;

  typedef struct {
    int amt;
    bit rf;
    bit se;
    bit rb;
    int a_k;
    int a_short;
    int a5;
    int a1;
    int a05;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Greedy payout computed directly from the amount and inventory
  function automatic void model(input int d, input int amt);
    int rem, k5, k1, k05;
    rem = amt;
    k5  = (rem / 10 < m5[d]) ? rem / 10 : m5[d];
    rem = rem - 10 * k5;
    k1  = (rem / 2 < m1[d]) ? rem / 2 : m1[d];
    rem = rem - 2 * k1;
    k05 = (rem < m05[d]) ? rem : m05[d];
    rem = rem - k05;
    exp_k[d] = 0;
    for (int i = 0; i < k5; i++) begin exp_code[d][exp_k[d]] = 2; exp_k[d] = exp_k[d] + 1; end
    for (int i = 0; i < k1; i++) begin exp_code[d][exp_k[d]] = 1; exp_k[d] = exp_k[d] + 1; end
    for (int i = 0; i < k05; i++) begin exp_code[d][exp_k[d]] = 0; exp_k[d] = exp_k[d] + 1; end
    exp_short[d] = rem;
    m5[d]  = m5[d] - k5;
    m1[d]  = m1[d] - k1;
    m05[d] = m05[d] - k05;
  endfunction

  task automatic check_counts(input string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_d%0d_n5", tag, d), int'(c5[d]), m5[d]);
      check($sformatf("%s_d%0d_n1", tag, d), int'(c1[d]), m1[d]);
      check($sformatf("%s_d%0d_n05", tag, d), int'(c05[d]), m05[d]);
    end
  endtask

  task automatic do_refill();
    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    for (int d = 0; d < ND; d++) begin
      m5[d] = init5[d]; m1[d] = init1[d]; m05[d] = init05[d];
    end
    check_counts("refill");
  endtask

  task automatic run_req(input int amt, input bit second_edge, input bit refill_busy);
    int cyc, post;
    bit all_done;
    for (int d = 0; d < ND; d++) begin
      model(d, amt);
      got_k[d] = 0; done_cyc[d] = -1; done_cnt[d] = 0; busy_cnt[d] = 0;
    end
    @(negedge clk);
    coin_sum   = 6'(amt);
    charge_ind = 1'b1;
    cyc  = 0;
    post = 0;
    while (cyc < 400 && post < 4) begin
      @(negedge clk);
      cyc++;
      all_done = 1'b1;
      for (int d = 0; d < ND; d++) begin
        if (ej[d]) begin
          if (got_k[d] < 64) begin
            got_cyc[d][got_k[d]] = cyc;
            got_val[d][got_k[d]] = int'(ejv[d]);
          end
          got_k[d]++;
        end
        if (dn[d]) begin
          if (done_cnt[d] == 0) done_cyc[d] = cyc;
          done_cnt[d]++;
        end
        if (bsy[d]) busy_cnt[d]++;
        if (done_cnt[d] == 0) all_done = 1'b0;
      end
      if (second_edge && cyc == 3) charge_ind = 1'b0;
      if (second_edge && cyc == 4) charge_ind = 1'b1;
      if (refill_busy) refill = (cyc >= 3 && cyc <= 5);
      if (all_done) post++;
    end
    charge_ind = 1'b0;
    refill     = 1'b0;
    for (int d = 0; d < ND; d++) begin
      int n;
      check($sformatf("req%0d_d%0d_ejects", amt, d), got_k[d], exp_k[d]);
      n = (got_k[d] < exp_k[d]) ? got_k[d] : exp_k[d];
      if (n > 64) n = 64;
      for (int i = 0; i < n; i++) begin
        check($sformatf("req%0d_d%0d_ej%0d_val", amt, d, i), got_val[d][i], exp_code[d][i]);
        check($sformatf("req%0d_d%0d_ej%0d_cyc", amt, d, i), got_cyc[d][i], 2 + i * (G + 2));
      end
      check($sformatf("req%0d_d%0d_done_cnt", amt, d), done_cnt[d], 1);
      check($sformatf("req%0d_d%0d_done_cyc", amt, d), done_cyc[d], 2 + exp_k[d] * (G + 2));
      check($sformatf("req%0d_d%0d_busy_cyc", amt, d), busy_cnt[d], 1 + exp_k[d] * (G + 2));
      check($sformatf("req%0d_d%0d_short", amt, d), int'(sht[d]), exp_short[d]);
    end
    check_counts($sformatf("req%0d", amt));
  endtask

  initial begin
    int ev_cnt;
    tbl[0] = '{amt: 15, rf: 0, se: 0, rb: 0, a_k: 4, a_short: 0, a5: 7, a1: 18, a05: 19};
    tbl[1] = '{amt: 0,  rf: 0, se: 0, rb: 0, a_k: 0, a_short: 0, a5: 7, a1: 18, a05: 19};
    tbl[2] = '{amt: 10, rf: 1, se: 0, rb: 0, a_k: 1, a_short: 0, a5: 7, a1: 20, a05: 20};
    tbl[3] = '{amt: 6,  rf: 1, se: 0, rb: 0, a_k: 3, a_short: 0, a5: 8, a1: 17, a05: 20};
    tbl[4] = '{amt: 12, rf: 1, se: 1, rb: 1, a_k: 2, a_short: 0, a5: 7, a1: 19, a05: 20};

    for (int d = 0; d < ND; d++) begin
      m5[d] = init5[d]; m1[d] = init1[d]; m05[d] = init05[d];
    end

    repeat (2) @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("rst_d%0d_eject", d), int'(ej[d]), 0);
      check($sformatf("rst_d%0d_busy", d), int'(bsy[d]), 0);
      check($sformatf("rst_d%0d_done", d), int'(dn[d]), 0);
      check($sformatf("rst_d%0d_short", d), int'(sht[d]), 0);
      check($sformatf("rst_d%0d_val", d), int'(ejv[d]), 0);
    end
    check_counts("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 5; r++) begin
      if (tbl[r].rf) do_refill();
      run_req(tbl[r].amt, tbl[r].se, tbl[r].rb);
      check($sformatf("tbl%0d_a_ejects", r), got_k[0], tbl[r].a_k);
      check($sformatf("tbl%0d_a_short", r), int'(sht[0]), tbl[r].a_short);
      check($sformatf("tbl%0d_a_n5", r), int'(c5[0]), tbl[r].a5);
      check($sformatf("tbl%0d_a_n1", r), int'(c1[0]), tbl[r].a1);
      check($sformatf("tbl%0d_a_n05", r), int'(c05[0]), tbl[r].a05);
      if (r == 3) begin
        check("tbl3_c_short", int'(sht[2]), 3);
        check("tbl3_c_n1", int'(c1[2]), 0);
        check("tbl3_c_n05", int'(c05[2]), 0);
      end
    end

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) do_refill();
      run_req(int'($urandom_range(0, 63)), 1'b0, 1'b0);
    end

    // Reset in the middle of a payout, right after the first eject
    do_refill();
    @(negedge clk);
    coin_sum   = 6'd15;
    charge_ind = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_first_eject", int'(ej[0]), 1);
    check("midrst_first_val", int'(ejv[0]), 2);
    rst_n      = 1'b0;
    charge_ind = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      m5[d] = init5[d]; m1[d] = init1[d]; m05[d] = init05[d];
      check($sformatf("midrst_d%0d_eject", d), int'(ej[d]), 0);
      check($sformatf("midrst_d%0d_busy", d), int'(bsy[d]), 0);
      check($sformatf("midrst_d%0d_done", d), int'(dn[d]), 0);
    end
    check_counts("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    ev_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) if (ej[d] || dn[d] || bsy[d]) ev_cnt++;
    end
    check("midrst_quiet_after", ev_cnt, 0);
    run_req(15, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
